lc_fetch_ctl: RTL and testbench

Macroinstruction fetch sequencer for the location counter (LC). Owns the 26-bit byte-address LC and a one-word instruction buffer. Issues word reads to the memory interface whenever the buffer does not hold the word LC points at, and presents the current 16-bit macroinstruction to the dispatch logic. Sits between the LC datapath, the destination-LC write path and the VMA/MD memory request port.

---
 rtl/lc_fetch_ctl.sv | 140 ++++++++++++++
 tb/tb_lc_fetch_ctl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lc_fetch_ctl.sv
// Location-counter fetch sequencer: keeps a one-word instruction buffer in step with lc
// and issues word reads over the VMA/MD request port whenever the buffer goes stale.
module lc_fetch_ctl #(
  parameter int LC_W = 26,
  parameter int MI_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lc_load,
  input  logic [LC_W-1:0]   lc_load_val,
  input  logic              mi_adv,
  input  logic              byte_mode,
  output logic              mem_req,
  output logic [LC_W-3:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [2*MI_W-1:0] mem_data,
  output logic              mi_valid,
  output logic [MI_W-1:0]   mi,
  output logic [LC_W-1:0]   lc,
  output logic              needfetch
);

  localparam int WA_W   = LC_W - 2;
  localparam int WORD_W = 2 * MI_W;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    REQ         = 2'd1,
    IDLE        = 2'd2,
    DISCARD     = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [LC_W-1:0]     lc_reg, lc_next;
  logic [WORD_W-1:0]   buf_reg, buf_next;
  logic [WA_W-1:0]     tag_reg, tag_next;
  logic                valid_reg, valid_next;
  logic [WA_W-1:0]     mem_addr_reg, mem_addr_next;
  logic [LC_W-1:0]     lc_inc;
  logic                adv_ok;

  assign lc_inc = lc_reg + (byte_mode ? LC_W'(1) : LC_W'(2));
  assign adv_ok = mi_adv & mi_valid & ~lc_load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= FETCH_ISSUE;
      lc_reg       <= '0;
      buf_reg      <= '0;
      tag_reg      <= '0;
      valid_reg    <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lc_reg       <= lc_next;
      buf_reg      <= buf_next;
      tag_reg      <= tag_next;
      valid_reg    <= valid_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lc_next       = lc_reg;
    buf_next      = buf_reg;
    tag_next      = tag_reg;
    valid_next    = valid_reg;
    mem_addr_next = mem_addr_reg;

    case (state_reg)
      FETCH_ISSUE: begin
        // A load arriving here is folded straight into the request address.
        if (lc_load) lc_next = lc_load_val;
        mem_addr_next = lc_next[LC_W-1:2];
        state_next    = REQ;
      end

      REQ: begin
        if (lc_load) begin
          lc_next = lc_load_val;
          if (mem_ack) begin
            if (lc_load_val[LC_W-1:2] == mem_addr_reg) begin
              buf_next   = mem_data;
              tag_next   = mem_addr_reg;
              valid_next = 1'b1;
              state_next = IDLE;
            end else begin
              valid_next = 1'b0;
              state_next = FETCH_ISSUE;
            end
          end else begin
            state_next = DISCARD;
          end
        end else if (mem_ack) begin
          buf_next   = mem_data;
          tag_next   = mem_addr_reg;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end

      DISCARD: begin
        // The outstanding read must complete before a new one may be issued.
        if (lc_load) lc_next = lc_load_val;
        if (mem_ack) state_next = FETCH_ISSUE;
      end

      IDLE: begin
        if (lc_load) begin
          lc_next = lc_load_val;
          if (lc_load_val[LC_W-1:2] != tag_reg) begin
            valid_next = 1'b0;
            state_next = FETCH_ISSUE;
          end
        end else if (adv_ok) begin
          lc_next = lc_inc;
          if (lc_inc[LC_W-1:2] != tag_reg) begin
            valid_next = 1'b0;
            state_next = FETCH_ISSUE;
          end
        end
      end

      default: state_next = FETCH_ISSUE;
    endcase
  end

  assign mem_req   = (state_reg == REQ) || (state_reg == DISCARD);
  assign mem_addr  = mem_addr_reg;
  assign lc        = lc_reg;
  assign mi_valid  = valid_reg && (tag_reg == lc_reg[LC_W-1:2]) && (state_reg == IDLE);
  assign needfetch = ~mi_valid;

  // Halfword select by lc[1]; lc[0] never participates.
  for (genvar gi = 0; gi < MI_W; gi++) begin : g_mi_sel
    assign mi[gi] = lc_reg[1] ? buf_reg[MI_W+gi] : buf_reg[gi];
  end

endmodule

// File: tb/tb_lc_fetch_ctl.sv
// Directed bench for lc_fetch_ctl: hand-computed vectors covering fetch, advance,
// reload-while-pending, byte mode, wrap and reset during an acknowledged request.
module tb_lc_fetch_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        lc_load;
  logic [25:0] lc_load_val;
  logic        mi_adv;
  logic        byte_mode;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        mi_valid;
  logic [15:0] mi;
  logic [25:0] lc;
  logic        needfetch;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lc_fetch_ctl dut (
    .clk         (clk),
    .reset       (reset),
    .lc_load     (lc_load),
    .lc_load_val (lc_load_val),
    .mi_adv      (mi_adv),
    .byte_mode   (byte_mode),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .mi_valid    (mi_valid),
    .mi          (mi),
    .lc          (lc),
    .needfetch   (needfetch)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; lc_load = 1'b0; lc_load_val = '0; mi_adv = 1'b0;
    byte_mode = 1'b0; mem_ack = 1'b0; mem_data = '0;
    tick(); tick();
    chk("rst_req",       32'(mem_req),   32'd0);
    chk("rst_addr",      32'(mem_addr),  32'd0);
    chk("rst_valid",     32'(mi_valid),  32'd0);
    chk("rst_needfetch", 32'(needfetch), 32'd1);
    chk("rst_lc",        32'(lc),        32'd0);

    // First fetch of word 0.
    reset = 1'b1;
    tick();
    chk("f0_req",  32'(mem_req),  32'd1);
    chk("f0_addr", 32'(mem_addr), 32'd0);
    mem_ack = 1'b1; mem_data = 32'hBEEF1234;
    tick();
    mem_ack = 1'b0;
    chk("f0_valid", 32'(mi_valid),  32'd1);
    chk("f0_mi",    32'(mi),        32'h1234);
    chk("f0_nf",    32'(needfetch), 32'd0);
    chk("f0_noreq", 32'(mem_req),   32'd0);

    // Halfword advance within the word, then across it.
    mi_adv = 1'b1;
    tick();
    chk("adv1_lc",    32'(lc),      32'd2);
    chk("adv1_mi",    32'(mi),      32'hBEEF);
    chk("adv1_valid", 32'(mi_valid),32'd1);
    chk("adv1_noreq", 32'(mem_req), 32'd0);
    tick();
    mi_adv = 1'b0;
    chk("adv2_lc",    32'(lc),       32'd4);
    chk("adv2_valid", 32'(mi_valid), 32'd0);
    tick();
    chk("f1_req",  32'(mem_req),  32'd1);
    chk("f1_addr", 32'(mem_addr), 32'd1);

    // Reload while the fetch of word 1 is pending.
    lc_load = 1'b1; lc_load_val = 26'h000100;
    tick();
    lc_load = 1'b0;
    chk("dis_req",   32'(mem_req),  32'd1);
    chk("dis_lc",    32'(lc),       32'h100);
    chk("dis_addr",  32'(mem_addr), 32'd1);
    tick();
    chk("dis_hold",  32'(mem_req),  32'd1);
    mem_ack = 1'b1; mem_data = 32'h11112222;
    tick();
    mem_ack = 1'b0;
    chk("dis_drop_req",   32'(mem_req),  32'd0);
    chk("dis_drop_valid", 32'(mi_valid), 32'd0);
    tick();
    chk("f40_req",  32'(mem_req),  32'd1);
    chk("f40_addr", 32'(mem_addr), 32'h40);
    mem_ack = 1'b1; mem_data = 32'hCAFE5678;
    tick();
    mem_ack = 1'b0;
    chk("f40_valid", 32'(mi_valid), 32'd1);
    chk("f40_mi",    32'(mi),       32'h5678);

    // A stray ack while IDLE must not disturb the buffer.
    mem_ack = 1'b1; mem_data = 32'hDEADDEAD;
    tick();
    mem_ack = 1'b0;
    chk("stray_mi",  32'(mi),      32'h5678);
    chk("stray_req", 32'(mem_req), 32'd0);

    // Same-word reload keeps the buffer; then byte-mode stepping.
    lc_load = 1'b1; lc_load_val = 26'h000102;
    tick();
    lc_load = 1'b0;
    chk("ld102_lc",    32'(lc),       32'h102);
    chk("ld102_mi",    32'(mi),       32'hCAFE);
    chk("ld102_noreq", 32'(mem_req),  32'd0);
    byte_mode = 1'b1; mi_adv = 1'b1;
    tick();
    chk("b1_lc",    32'(lc),       32'h103);
    chk("b1_mi",    32'(mi),       32'hCAFE);
    chk("b1_valid", 32'(mi_valid), 32'd1);
    tick();
    mi_adv = 1'b0; byte_mode = 1'b0;
    chk("b2_lc",    32'(lc),       32'h104);
    chk("b2_valid", 32'(mi_valid), 32'd0);
    tick();
    chk("f41_addr", 32'(mem_addr), 32'h41);
    mem_ack = 1'b1; mem_data = 32'hAAAA5555;
    tick();
    mem_ack = 1'b0;
    chk("f41_mi", 32'(mi), 32'h5555);

    // lc_load beats mi_adv in the same cycle.
    lc_load = 1'b1; lc_load_val = 26'h000106; mi_adv = 1'b1;
    tick();
    lc_load = 1'b0; mi_adv = 1'b0;
    chk("prio_lc", 32'(lc), 32'h106);
    chk("prio_mi", 32'(mi), 32'hAAAA);

    // Wrap at the top of the address space; mi_adv ignored while fetching.
    lc_load = 1'b1; lc_load_val = 26'h3FFFFFE;
    tick();
    lc_load = 1'b0;
    chk("wrap_ld_valid", 32'(mi_valid), 32'd0);
    mi_adv = 1'b1;
    tick();
    chk("wrap_addr",   32'(mem_addr), 32'hFFFFFF);
    chk("wrap_ign_lc", 32'(lc),       32'h3FFFFFE);
    mi_adv = 1'b0; mem_ack = 1'b1; mem_data = 32'h9876ABCD;
    tick();
    mem_ack = 1'b0;
    chk("wrap_mi", 32'(mi), 32'h9876);
    mi_adv = 1'b1;
    tick();
    mi_adv = 1'b0;
    chk("wrap_lc", 32'(lc), 32'd0);
    tick();
    chk("wrap_req",  32'(mem_req),  32'd1);
    chk("wrap_addr0",32'(mem_addr), 32'd0);

    // Reset coinciding with an ack: reset wins.
    reset = 1'b0; mem_ack = 1'b1; mem_data = 32'h12345678;
    tick();
    chk("rr_req",   32'(mem_req),   32'd0);
    chk("rr_addr",  32'(mem_addr),  32'd0);
    chk("rr_lc",    32'(lc),        32'd0);
    chk("rr_valid", 32'(mi_valid),  32'd0);
    chk("rr_nf",    32'(needfetch), 32'd1);
    reset = 1'b1; mem_ack = 1'b0;
    tick();
    chk("rr_refetch", 32'(mem_req),  32'd1);
    chk("rr_invalid", 32'(mi_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
